// File: rtl/memShare_config_pkg.sv
// Shared configuration for the column-bank IB-LUT memShare datapath: geometry constants
// for the GP1/GP2 IB-RAMs and the preload FSM state type.
package memShare_config_pkg;

  localparam int QUAN_SIZE          = 3;
  localparam int GP1_COL_SEL_WIDTH  = 3;
  localparam int GP2_COL_SEL_WIDTH  = 3;
  localparam int GP1_COL_BANK_NUM   = 2 ** GP1_COL_SEL_WIDTH;
  localparam int GP2_COL_BANK_NUM   = 2 ** GP2_COL_SEL_WIDTH;
  localparam int GP1_RAM_ADDR_WIDTH = QUAN_SIZE + GP1_COL_SEL_WIDTH;
  localparam int GP2_RAM_ADDR_WIDTH = QUAN_SIZE + GP2_COL_SEL_WIDTH;
  localparam int GP1_VN_LOAD_CYCLE  = (2 ** QUAN_SIZE) * GP1_COL_BANK_NUM;
  localparam int GP2_VN_LOAD_CYCLE  = (2 ** QUAN_SIZE) * GP2_COL_BANK_NUM;

  // The shared address counter must cover the wider of the two banks.
  localparam int LOAD_SEL_WIDTH = (GP1_COL_SEL_WIDTH > GP2_COL_SEL_WIDTH) ?
                                  GP1_COL_SEL_WIDTH : GP2_COL_SEL_WIDTH;

  typedef enum logic [1:0] {
    IB_LOAD_IDLE,
    IB_LOAD_GP1,
    IB_LOAD_GP2,
    IB_LOAD_DONE
  } ib_load_state_e;

endpackage

// File: rtl/ib_load_addr_cnt.sv
// Row/bank write-address counter: row is the inner (fast) index, bank the outer one.
// last_o flags the final address of the current pass, whose terminal bank is supplied by the caller.
module ib_load_addr_cnt #(
  parameter int QUAN_SIZE     = 3,
  parameter int COL_SEL_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     inc_i,
  input  logic [COL_SEL_WIDTH-1:0] last_bank_i,
  output logic [QUAN_SIZE-1:0]     row_o,
  output logic [COL_SEL_WIDTH-1:0] bank_o,
  output logic                     last_o
);

  logic [QUAN_SIZE-1:0]     row_q;
  logic [COL_SEL_WIDTH-1:0] bank_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      row_q  <= '0;
      bank_q <= '0;
    end else if (inc_i) begin
      row_q <= row_q + 1'b1;
      if (&row_q) begin
        bank_q <= bank_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign bank_o = bank_q;
  assign last_o = (&row_q) && (bank_q == last_bank_i);

endmodule

// File: rtl/ib_colbank_ram_loader.sv
// Streams preload IB-LUT words into the GP1 then GP2 IB-RAM write ports.
// Handshake: a word moves when lut_valid & lut_ready at a rising edge; lut_ready never depends on lut_valid.
module ib_colbank_ram_loader
  import memShare_config_pkg::*;
(
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          load_gp1_en,
  input  logic                          load_gp2_en,
  input  logic                          load_abort,
  input  logic [QUAN_SIZE-1:0]          lut_data,
  input  logic                          lut_valid,
  output logic                          lut_ready,
  output logic                          gp1_we,
  output logic [GP1_RAM_ADDR_WIDTH-1:0] gp1_waddr,
  output logic [QUAN_SIZE-1:0]          gp1_wdata,
  output logic                          gp2_we,
  output logic [GP2_RAM_ADDR_WIDTH-1:0] gp2_waddr,
  output logic [QUAN_SIZE-1:0]          gp2_wdata,
  output logic                          load_busy,
  output logic                          load_done,
  output logic                          start_err,
  output ib_load_state_e                dbg_state
);

  ib_load_state_e state_q, state_d;
  logic gp2_en_q, gp2_en_d;
  // drain_q: the final word of the load was accepted; wait for its write strobe before DONE.
  logic drain_q, drain_d;

  logic                      transfer;
  logic                      cnt_clr;
  logic                      cnt_last;
  logic [QUAN_SIZE-1:0]      cnt_row;
  logic [LOAD_SEL_WIDTH-1:0] cnt_bank;
  logic [LOAD_SEL_WIDTH-1:0] last_bank;

  logic                          gp1_we_q, gp2_we_q;
  logic [GP1_RAM_ADDR_WIDTH-1:0] gp1_waddr_q;
  logic [GP2_RAM_ADDR_WIDTH-1:0] gp2_waddr_q;
  logic [QUAN_SIZE-1:0]          gp1_wdata_q, gp2_wdata_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IB_LOAD_IDLE;
      gp2_en_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gp2_en_q <= gp2_en_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gp2_en_d = gp2_en_q;
    drain_d  = drain_q;
    if (load_abort) begin
      state_d = IB_LOAD_IDLE;
      drain_d = 1'b0;
    end else begin
      case (state_q)
        IB_LOAD_IDLE: begin
          if (load_start) begin
            gp2_en_d = load_gp2_en;
            if (load_gp1_en)      state_d = IB_LOAD_GP1;
            else if (load_gp2_en) state_d = IB_LOAD_GP2;
          end
        end
        IB_LOAD_GP1: begin
          if (drain_q) begin
            state_d = IB_LOAD_DONE;
            drain_d = 1'b0;
          end else if (transfer && cnt_last) begin
            if (gp2_en_q) state_d = IB_LOAD_GP2;
            else          drain_d = 1'b1;
          end
        end
        IB_LOAD_GP2: begin
          if (drain_q) begin
            state_d = IB_LOAD_DONE;
            drain_d = 1'b0;
          end else if (transfer && cnt_last) begin
            drain_d = 1'b1;
          end
        end
        IB_LOAD_DONE: state_d = IB_LOAD_IDLE;
        default:      state_d = IB_LOAD_IDLE;
      endcase
    end
  end

  always_comb begin
    load_busy = (state_q == IB_LOAD_GP1) || (state_q == IB_LOAD_GP2);
    lut_ready = load_busy && !drain_q && !load_abort;
    load_done = (state_q == IB_LOAD_DONE);
    start_err = load_start && ((state_q != IB_LOAD_IDLE) || (!load_gp1_en && !load_gp2_en));
    dbg_state = state_q;
  end

  assign transfer  = lut_valid && lut_ready;
  assign cnt_clr   = load_abort || (transfer && cnt_last);
  assign last_bank = (state_q == IB_LOAD_GP2) ? LOAD_SEL_WIDTH'(GP2_COL_BANK_NUM - 1)
                                              : LOAD_SEL_WIDTH'(GP1_COL_BANK_NUM - 1);

  ib_load_addr_cnt #(
    .QUAN_SIZE     (QUAN_SIZE),
    .COL_SEL_WIDTH (LOAD_SEL_WIDTH)
  ) u_addr_cnt (
    .clk_i       (sys_clk),
    .rst_i       (rst),
    .clr_i       (cnt_clr),
    .inc_i       (transfer),
    .last_bank_i (last_bank),
    .row_o       (cnt_row),
    .bank_o      (cnt_bank),
    .last_o      (cnt_last)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      gp1_we_q    <= 1'b0;
      gp1_waddr_q <= '0;
      gp1_wdata_q <= '0;
      gp2_we_q    <= 1'b0;
      gp2_waddr_q <= '0;
      gp2_wdata_q <= '0;
    end else begin
      gp1_we_q <= transfer && (state_q == IB_LOAD_GP1);
      gp2_we_q <= transfer && (state_q == IB_LOAD_GP2);
      if (transfer && (state_q == IB_LOAD_GP1)) begin
        gp1_waddr_q <= {cnt_bank[GP1_COL_SEL_WIDTH-1:0], cnt_row};
        gp1_wdata_q <= lut_data;
      end
      if (transfer && (state_q == IB_LOAD_GP2)) begin
        gp2_waddr_q <= {cnt_bank[GP2_COL_SEL_WIDTH-1:0], cnt_row};
        gp2_wdata_q <= lut_data;
      end
    end
  end

  assign gp1_we    = gp1_we_q;
  assign gp1_waddr = gp1_waddr_q;
  assign gp1_wdata = gp1_wdata_q;
  assign gp2_we    = gp2_we_q;
  assign gp2_waddr = gp2_waddr_q;
  assign gp2_wdata = gp2_wdata_q;

endmodule

// File: tb/tb_ib_colbank_ram_loader.sv
// Directed-sequence bench for ib_colbank_ram_loader: a source feeds a word list through the
// handshake, a monitor logs every RAM write, and each pass is compared with the list order.
module tb_ib_colbank_ram_loader;
  import memShare_config_pkg::*;

  logic                          sys_clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          load_start = 1'b0;
  logic                          load_gp1_en = 1'b0;
  logic                          load_gp2_en = 1'b0;
  logic                          load_abort = 1'b0;
  logic [QUAN_SIZE-1:0]          lut_data = '0;
  logic                          lut_valid = 1'b0;
  logic                          lut_ready;
  logic                          gp1_we, gp2_we;
  logic [GP1_RAM_ADDR_WIDTH-1:0] gp1_waddr;
  logic [GP2_RAM_ADDR_WIDTH-1:0] gp2_waddr;
  logic [QUAN_SIZE-1:0]          gp1_wdata, gp2_wdata;
  logic                          load_busy, load_done, start_err;
  ib_load_state_e                dbg_state;

  ib_colbank_ram_loader dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_gp1_en (load_gp1_en),
    .load_gp2_en (load_gp2_en),
    .load_abort  (load_abort),
    .lut_data    (lut_data),
    .lut_valid   (lut_valid),
    .lut_ready   (lut_ready),
    .gp1_we      (gp1_we),
    .gp1_waddr   (gp1_waddr),
    .gp1_wdata   (gp1_wdata),
    .gp2_we      (gp2_we),
    .gp2_waddr   (gp2_waddr),
    .gp2_wdata   (gp2_wdata),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .start_err   (start_err),
    .dbg_state   (dbg_state)
  );

  // ---- clock / cycle count ----
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---- scoreboard state ----
  int n_compared = 0;
  int n_mismatch = 0;
  logic [QUAN_SIZE-1:0] src_w[128];
  int src_idx = 0;
  int start_cyc = 0;
  int w1_a[$], w1_d[$], w1_c[$];
  int w2_a[$], w2_d[$], w2_c[$];
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, overlap_cnt = 0;

  // ---- monitor: samples on the falling edge ----
  always @(negedge sys_clk) begin
    if (gp1_we) begin
      w1_a.push_back(int'(gp1_waddr)); w1_d.push_back(int'(gp1_wdata)); w1_c.push_back(cyc);
    end
    if (gp2_we) begin
      w2_a.push_back(int'(gp2_waddr)); w2_d.push_back(int'(gp2_wdata)); w2_c.push_back(cyc);
    end
    if (gp1_we && gp2_we) overlap_cnt++;
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (start_err) err_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    w1_a.delete(); w1_d.delete(); w1_c.delete();
    w2_a.delete(); w2_d.delete(); w2_c.delete();
    done_cnt = 0; err_cnt = 0; overlap_cnt = 0;
  endtask

  task automatic fill_src(input bit modulo);
    for (int k = 0; k < 128; k++) src_w[k] = modulo ? QUAN_SIZE'(k % 8) : QUAN_SIZE'($urandom_range(0, 7));
  endtask

  // Expected pass: word base+i lands at address i, for i = 0..n_exp-1, in that order.
  task automatic check_pass(input string tag, input int gp, input int n_exp, input int base);
    int n, bad, a, d;
    n = (gp == 1) ? w1_a.size() : w2_a.size();
    chk({tag, "_count"}, n, n_exp);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a = (gp == 1) ? w1_a[i] : w2_a[i];
      d = (gp == 1) ? w1_d[i] : w2_d[i];
      if (i >= n_exp || base + i > 127) bad++;
      else if (a != i || d != int'(src_w[base + i])) bad++;
    end
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, int'(lut_ready), 0);
    chk({tag, "_gp1_we"}, int'(gp1_we), 0);
    chk({tag, "_gp2_we"}, int'(gp2_we), 0);
    chk({tag, "_addr_data"}, int'({gp1_waddr, gp1_wdata, gp2_waddr, gp2_wdata}), 0);
    chk({tag, "_busy"}, int'(load_busy), 0);
    chk({tag, "_done"}, int'(load_done), 0);
    chk({tag, "_err"}, int'(start_err), 0);
    chk({tag, "_state"}, int'(dbg_state), int'(IB_LOAD_IDLE));
  endtask

  // Called at posedge+1; the start pulse is sampled on the next rising edge.
  task automatic start_load(input bit e1, input bit e2);
    load_start = 1'b1; load_gp1_en = e1; load_gp2_en = e2; lut_valid = 1'b0;
    src_idx = 0; start_cyc = cyc;
    @(posedge sys_clk); #1;
    load_start = 1'b0;
  endtask

  // Source driver: offers src_w[src_idx] until taken; stops at load_done, at stop_at, or on budget.
  task automatic feed(input int n_words, input int vpct, input int stop_at, input int max_cyc);
    bit done_seen;
    int c;
    done_seen = 1'b0;
    c = 0;
    while (!done_seen && src_idx != stop_at && c < max_cyc) begin
      lut_valid = (src_idx < n_words) && ($urandom_range(0, 99) < vpct);
      lut_data = (src_idx < 128) ? src_w[src_idx] : '0;
      load_start = 1'b0; load_abort = 1'b0;
      @(negedge sys_clk);
      if (load_done) done_seen = 1'b1;
      if (lut_valid && lut_ready) src_idx++;
      @(posedge sys_clk); #1;
      c++;
    end
    chk("feed_budget", int'(c >= max_cyc), 0);
    lut_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge sys_clk); #1; end
  endtask

  initial begin
    // ---- reset ----
    rst = 1'b1;
    idle_cycles(3);
    @(negedge sys_clk);
    check_quiet("reset");
    @(posedge sys_clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // ---- full load, valid always high, data k%8 ----
    fill_src(1'b1);
    clear_logs();
    start_load(1'b1, 1'b1);
    feed(128, 100, -1, 400);
    check_pass("full_gp1", 1, 64, 0);
    check_pass("full_gp2", 2, 64, 64);
    chk("full_start_to_done", done_cyc - start_cyc, 130);
    chk("full_done_after_we", (w2_c.size() > 0) ? done_cyc - w2_c[$] : -1, 1);
    chk("full_switch_gap", (w1_c.size() > 0 && w2_c.size() > 0) ? w2_c[0] - w1_c[$] : -1, 1);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_overlap", overlap_cnt, 0);
    idle_cycles(2);

    // ---- GP2 only ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b0, 1'b1);
    feed(64, 100, -1, 300);
    check_pass("gp2only_gp1", 1, 0, 0);
    check_pass("gp2only_gp2", 2, 64, 0);
    chk("gp2only_done_cnt", done_cnt, 1);
    idle_cycles(2);

    // ---- GP1 only ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b0);
    feed(64, 100, -1, 300);
    check_pass("gp1only_gp1", 1, 64, 0);
    check_pass("gp1only_gp2", 2, 0, 0);
    chk("gp1only_done_cnt", done_cnt, 1);
    idle_cycles(2);

    // ---- random 50% valid ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b1);
    feed(128, 50, -1, 2000);
    check_pass("rand_gp1", 1, 64, 0);
    check_pass("rand_gp2", 2, 64, 64);
    chk("rand_done_cnt", done_cnt, 1);
    chk("rand_overlap", overlap_cnt, 0);
    idle_cycles(2);

    // ---- abort while GP1 word 20 is offered ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b1);
    feed(128, 100, 20, 300);
    load_abort = 1'b1; lut_valid = 1'b1; lut_data = src_w[20];
    @(negedge sys_clk);
    chk("abort_ready_same_cycle", int'(lut_ready), 0);
    @(posedge sys_clk); #1;
    load_abort = 1'b0;
    @(negedge sys_clk);
    chk("abort_ready_next", int'(lut_ready), 0);
    chk("abort_state", int'(dbg_state), int'(IB_LOAD_IDLE));
    chk("abort_busy", int'(load_busy), 0);
    @(posedge sys_clk); #1;
    lut_valid = 1'b0;
    idle_cycles(4);
    check_pass("abort_gp1", 1, 20, 0);
    check_pass("abort_gp2", 2, 0, 0);
    chk("abort_no_done", done_cnt, 0);

    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b0);
    feed(64, 100, -1, 300);
    check_pass("restart_gp1", 1, 64, 0);
    chk("restart_done_cnt", done_cnt, 1);
    idle_cycles(2);

    // ---- load_start at GP2 word 5 ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b1);
    feed(128, 100, 69, 300);
    load_start = 1'b1; lut_valid = 1'b1; lut_data = src_w[69];
    @(negedge sys_clk);
    chk("busy_start_err", int'(start_err), 1);
    chk("busy_start_busy", int'(load_busy), 1);
    if (lut_ready) src_idx++;
    @(posedge sys_clk); #1;
    load_start = 1'b0;
    feed(128, 100, -1, 300);
    check_pass("busystart_gp1", 1, 64, 0);
    check_pass("busystart_gp2", 2, 64, 64);
    chk("busystart_done_cnt", done_cnt, 1);
    chk("busystart_err_cnt", err_cnt, 1);
    idle_cycles(2);

    // ---- load_start with both enables low ----
    clear_logs();
    load_start = 1'b1; load_gp1_en = 1'b0; load_gp2_en = 1'b0; lut_valid = 1'b1;
    @(negedge sys_clk);
    chk("noen_start_err", int'(start_err), 1);
    @(posedge sys_clk); #1;
    load_start = 1'b0;
    @(negedge sys_clk);
    chk("noen_state", int'(dbg_state), int'(IB_LOAD_IDLE));
    chk("noen_ready", int'(lut_ready), 0);
    @(posedge sys_clk); #1;
    idle_cycles(4);
    lut_valid = 1'b0;
    chk("noen_writes", w1_a.size() + w2_a.size(), 0);
    chk("noen_err_cnt", err_cnt, 1);

    // ---- reset at GP2 word 30 ----
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b1);
    feed(128, 100, 94, 300);
    rst = 1'b1; lut_valid = 1'b1; lut_data = src_w[94];
    @(posedge sys_clk); #1;
    rst = 1'b0; lut_valid = 1'b0;
    @(negedge sys_clk);
    check_quiet("midrst");
    @(posedge sys_clk); #1;
    idle_cycles(1);
    fill_src(1'b0);
    clear_logs();
    start_load(1'b1, 1'b0);
    feed(64, 100, -1, 300);
    check_pass("postrst_gp1", 1, 64, 0);
    check_pass("postrst_gp2", 2, 0, 0);
    chk("postrst_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
